// File: rtl/sram_controller_if.sv
// MEM-stage side of the SRAM controller: 32-bit word request/response handshake.
interface sram_controller_if;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [31:0] readData;
  logic        ready;

  modport master (
    output wr_en, rd_en, address, writeData,
    input  readData, ready
  );

  modport slave (
    input  wr_en, rd_en, address, writeData,
    output readData, ready
  );
endinterface

// File: rtl/sram_controller.sv
// 32-bit word access to a 16-bit external SRAM as two halfword phases (low first);
// ready stalls the MEM stage until the DONE cycle.
module sram_controller #(
  parameter int SRAM_ADDR_W  = 18,
  parameter int PHASE_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  sram_controller_if.slave       bus,
  inout  wire  [15:0]            SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_WE_N
);

  localparam int CNT_W = (PHASE_CYCLES > 2) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PHASE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } state_t;

  state_t                 state, state_next;
  logic [CNT_W-1:0]       cnt, cnt_next;
  logic                   op_wr;
  logic [SRAM_ADDR_W-2:0] base;
  logic [31:0]            wdata;
  logic [31:0]            rdata;
  logic [15:0]            dq_out;
  logic                   req;
  logic                   phase_end;
  logic                   unused_addr_bits;

  assign req       = bus.wr_en | bus.rd_en;
  assign phase_end = (cnt == LAST);
  assign unused_addr_bits = ^{bus.address[31:SRAM_ADDR_W+1], bus.address[1:0]};

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (req) begin
          state_next = LOW;
          cnt_next   = '0;
        end
      end
      LOW: begin
        if (phase_end) begin
          state_next = HIGH;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      HIGH: begin
        if (phase_end) begin
          state_next = DONE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Request is latched only in IDLE; write wins over a simultaneous read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_wr <= 1'b0;
      base  <= '0;
      wdata <= '0;
      rdata <= '0;
    end else begin
      if (state == IDLE && req) begin
        op_wr <= bus.wr_en;
        base  <= bus.address[SRAM_ADDR_W:2];
        wdata <= bus.writeData;
      end
      if (!op_wr && phase_end) begin
        if (state == LOW)  rdata[15:0]  <= SRAM_DQ;
        if (state == HIGH) rdata[31:16] <= SRAM_DQ;
      end
    end
  end

  // SRAM pins depend only on state and latched registers, never on live request inputs.
  always_comb begin
    SRAM_ADDR = '0;
    SRAM_WE_N = 1'b1;
    dq_out    = wdata[15:0];
    case (state)
      LOW: begin
        SRAM_ADDR = {base, 1'b0};
        SRAM_WE_N = ~op_wr;
      end
      HIGH: begin
        SRAM_ADDR = {base, 1'b1};
        SRAM_WE_N = ~op_wr;
        dq_out    = wdata[31:16];
      end
      default: begin
        SRAM_ADDR = '0;
        SRAM_WE_N = 1'b1;
      end
    endcase
  end

  assign SRAM_DQ      = SRAM_WE_N ? 'z : dq_out;
  assign bus.readData = rdata;
  assign bus.ready    = ((state == IDLE) && !req) || (state == DONE);

endmodule

// File: tb/tb_sram_controller.sv
// Directed self-checking bench for sram_controller with a registered-read SRAM model.
module tb_sram_controller;
  logic        clk = 1'b0;
  logic        rst;
  wire  [15:0] SRAM_DQ;
  logic [5:0]  SRAM_ADDR;
  logic        SRAM_WE_N;
  logic [15:0] mem [64] = '{default: 16'h0000};
  logic [15:0] rd_q = 16'h0000;
  int          total;
  int          bad;

  sram_controller_if bus ();

  sram_controller #(
    .SRAM_ADDR_W (6),
    .PHASE_CYCLES(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .SRAM_DQ  (SRAM_DQ),
    .SRAM_ADDR(SRAM_ADDR),
    .SRAM_WE_N(SRAM_WE_N)
  );

  always #5 clk = ~clk;

  // SRAM model: writes on the edge while WE_N is low, read data registered one edge late.
  always @(posedge clk) begin
    if (!SRAM_WE_N) mem[SRAM_ADDR] <= SRAM_DQ;
    rd_q <= mem[SRAM_ADDR];
  end
  assign SRAM_DQ = SRAM_WE_N ? rd_q : 16'bz;

  // Issues one request in the next cycle and holds it until ready; returns stall length.
  task automatic run_access(input logic wr, input logic rd, input logic [31:0] addr,
                            input logic [31:0] data, output int cycles, output logic [31:0] rdv);
    @(negedge clk);
    bus.wr_en = wr; bus.rd_en = rd; bus.address = addr; bus.writeData = data;
    #1;
    cycles = 0;
    while (bus.ready !== 1'b1 && cycles < 20) begin
      cycles++;
      @(negedge clk);
      #1;
    end
    rdv = bus.readData;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
  endtask

  task automatic test_power_on();
    #1;
    total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL por_ready: got %b want 1", bus.ready); end
    total++; if (SRAM_WE_N !== 1'b1) begin bad++; $display("FAIL por_we_n: got %b want 1", SRAM_WE_N); end
    total++; if (SRAM_ADDR !== 6'd0) begin bad++; $display("FAIL por_addr: got %h want 00", SRAM_ADDR); end
    total++; if (bus.readData !== 32'h0) begin bad++; $display("FAIL por_rdata: got %h want 00000000", bus.readData); end
  endtask

  task automatic test_write_read();
    int cyc;
    logic [31:0] rdv;
    run_access(1'b1, 1'b0, 32'd8, 32'hDEADBEEF, cyc, rdv);
    total++; if (cyc !== 5) begin bad++; $display("FAIL wr_stall: got %0d want 5", cyc); end
    total++; if (mem[4] !== 16'hBEEF) begin bad++; $display("FAIL wr_low: got %h want beef", mem[4]); end
    total++; if (mem[5] !== 16'hDEAD) begin bad++; $display("FAIL wr_high: got %h want dead", mem[5]); end
    total++; if (rdv !== 32'h0) begin bad++; $display("FAIL wr_rdata_hold: got %h want 00000000", rdv); end
    run_access(1'b0, 1'b1, 32'd8, 32'h0, cyc, rdv);
    total++; if (cyc !== 5) begin bad++; $display("FAIL rd_stall: got %0d want 5", cyc); end
    total++; if (rdv !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data: got %h want deadbeef", rdv); end
    @(negedge clk); #1;
    total++; if (bus.readData !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_idle_hold: got %h want deadbeef", bus.readData); end
  endtask

  task automatic test_simultaneous();
    int cyc;
    logic [31:0] rdv;
    run_access(1'b1, 1'b1, 32'd4, 32'h12345678, cyc, rdv);
    total++; if (cyc !== 5) begin bad++; $display("FAIL sim_stall: got %0d want 5", cyc); end
    total++; if (mem[2] !== 16'h5678) begin bad++; $display("FAIL sim_low: got %h want 5678", mem[2]); end
    total++; if (mem[3] !== 16'h1234) begin bad++; $display("FAIL sim_high: got %h want 1234", mem[3]); end
    total++; if (rdv !== 32'hDEADBEEF) begin bad++; $display("FAIL sim_rdata: got %h want deadbeef", rdv); end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    bus.wr_en = 1'b1; bus.address = 32'd256; bus.writeData = 32'hCAFEF00D;
    #1;
    total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL wrap_c0_ready: got %b want 0", bus.ready); end
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk); #1;
      if (c == 1) begin
        total++; if (SRAM_ADDR !== 6'd0) begin bad++; $display("FAIL wrap_addr_lo: got %h want 00", SRAM_ADDR); end
        total++; if (SRAM_WE_N !== 1'b0) begin bad++; $display("FAIL wrap_we_lo: got %b want 0", SRAM_WE_N); end
        total++; if (SRAM_DQ !== 16'hF00D) begin bad++; $display("FAIL wrap_dq_lo: got %h want f00d", SRAM_DQ); end
        // Busy-time input changes must be ignored
        bus.address = 32'd12; bus.writeData = 32'h0;
      end
      if (c == 3) begin
        total++; if (SRAM_ADDR !== 6'd1) begin bad++; $display("FAIL wrap_addr_hi: got %h want 01", SRAM_ADDR); end
        total++; if (SRAM_DQ !== 16'hCAFE) begin bad++; $display("FAIL wrap_dq_hi: got %h want cafe", SRAM_DQ); end
      end
      if (c == 5) begin
        total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL wrap_done_ready: got %b want 1", bus.ready); end
        bus.wr_en = 1'b0;
      end
    end
    total++; if (mem[0] !== 16'hF00D) begin bad++; $display("FAIL wrap_mem0: got %h want f00d", mem[0]); end
    total++; if (mem[1] !== 16'hCAFE) begin bad++; $display("FAIL wrap_mem1: got %h want cafe", mem[1]); end
    total++; if (mem[6] !== 16'h0000) begin bad++; $display("FAIL wrap_mem6: got %h want 0000", mem[6]); end
  endtask

  task automatic test_reset();
    @(negedge clk);
    bus.rd_en = 1'b1; bus.address = 32'd0;
    repeat (4) @(negedge clk);
    #1;
    total++; if (bus.readData !== 32'hDEADF00D) begin bad++; $display("FAIL rst_partial: got %h want deadf00d", bus.readData); end
    rst = 1'b0; bus.rd_en = 1'b0;
    #1;
    total++; if (SRAM_WE_N !== 1'b1) begin bad++; $display("FAIL rst_we_n: got %b want 1", SRAM_WE_N); end
    total++; if (SRAM_ADDR !== 6'd0) begin bad++; $display("FAIL rst_addr: got %h want 00", SRAM_ADDR); end
    total++; if (bus.readData !== 32'h0) begin bad++; $display("FAIL rst_rdata: got %h want 00000000", bus.readData); end
    total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", bus.ready); end
    total++; if (SRAM_DQ !== rd_q) begin bad++; $display("FAIL rst_dq_released: got %h want %h", SRAM_DQ, rd_q); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset_mid_write();
    int cyc;
    logic [31:0] rdv;
    @(negedge clk);
    bus.wr_en = 1'b1; bus.address = 32'd8; bus.writeData = 32'h11112222;
    repeat (3) @(negedge clk);
    #1;
    total++; if (SRAM_WE_N !== 1'b0) begin bad++; $display("FAIL rmw_high_active: got %b want 0", SRAM_WE_N); end
    total++; if (SRAM_ADDR !== 6'd5) begin bad++; $display("FAIL rmw_high_addr: got %h want 05", SRAM_ADDR); end
    rst = 1'b0; bus.wr_en = 1'b0;
    #1;
    total++; if (SRAM_WE_N !== 1'b1) begin bad++; $display("FAIL rmw_we_n: got %b want 1", SRAM_WE_N); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    total++; if (mem[4] !== 16'h2222) begin bad++; $display("FAIL rmw_low: got %h want 2222", mem[4]); end
    total++; if (mem[5] !== 16'hDEAD) begin bad++; $display("FAIL rmw_high_kept: got %h want dead", mem[5]); end
    total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL rmw_idle_ready: got %b want 1", bus.ready); end
    run_access(1'b0, 1'b1, 32'd8, 32'h0, cyc, rdv);
    total++; if (cyc !== 5) begin bad++; $display("FAIL rmw_rd_stall: got %0d want 5", cyc); end
    total++; if (rdv !== 32'hDEAD2222) begin bad++; $display("FAIL rmw_rd_data: got %h want dead2222", rdv); end
  endtask

  task automatic test_back_to_back();
    logic exp_ready;
    @(negedge clk);
    bus.rd_en = 1'b1; bus.address = 32'd0;
    for (int c = 0; c <= 11; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      exp_ready = (c == 5) || (c == 11);
      total++; if (bus.ready !== exp_ready) begin bad++; $display("FAIL b2b_ready_c%0d: got %b want %b", c, bus.ready, exp_ready); end
      total++; if (SRAM_WE_N !== 1'b1) begin bad++; $display("FAIL b2b_we_n_c%0d: got %b want 1", c, SRAM_WE_N); end
      total++; if (SRAM_DQ !== rd_q) begin bad++; $display("FAIL b2b_dq_c%0d: got %h want %h", c, SRAM_DQ, rd_q); end
      if (c == 5) begin
        total++; if (bus.readData !== 32'hCAFEF00D) begin bad++; $display("FAIL b2b_data0: got %h want cafef00d", bus.readData); end
        bus.address = 32'd8;
      end
      if (c == 11) begin
        total++; if (bus.readData !== 32'hDEAD2222) begin bad++; $display("FAIL b2b_data1: got %h want dead2222", bus.readData); end
        bus.rd_en = 1'b0;
      end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.address = '0; bus.writeData = '0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    test_power_on();
    test_write_read();
    test_simultaneous();
    test_wrap();
    test_reset();
    test_reset_mid_write();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sram_controller.md
# sram_controller

Initiator side of the external 16-bit SRAM interface. It sits between the MEM pipeline stage and the SRAM chip (or its behavioural model). Each 32-bit word read or write is split into two sequential 16-bit SRAM accesses, low halfword first. A `ready` signal stalls the pipeline until the access completes.

## Interface
Parameters:
- `SRAM_ADDR_W`, default 18: SRAM halfword-address width. The SRAM model uses 6.
- `PHASE_CYCLES`, default 2: clock cycles each halfword phase is held on the bus. Must be ≥ 2, because the SRAM registers read data one edge after the address is presented.

Ports:
- `clk`, input, 1: single clock; all state changes on posedge.
- `rst`, input, 1: asynchronous, active-low reset.
- `wr_en`, input, 1: 32-bit write request from MEM stage.
- `rd_en`, input, 1: 32-bit read request from MEM stage.
- `address`, input, 32: byte address. Bits [1:0] are ignored.
- `writeData`, input, 32: word to write.
- `readData`, output, 32: last completed read word.
- `ready`, output, 1: low means stall the pipeline; high means no request pending or the access is complete.
- `SRAM_DQ`, inout, 16: SRAM data bus. Driven only while `SRAM_WE_N`=0, high-Z otherwise.
- `SRAM_ADDR`, output, SRAM_ADDR_W: SRAM halfword address.
- `SRAM_WE_N`, output, 1: active-low SRAM write enable.

## Operation
- FSM states: IDLE → LOW → HIGH → DONE → IDLE.
- **IDLE:** if `wr_en|rd_en`, latch op, `address`, `writeData`, set the phase counter to 0 and go to LOW. Otherwise stay.
- **Simultaneous requests:** if `wr_en` and `rd_en` are both high, write wins. The read is dropped and `readData` is unchanged.
- **LOW / HIGH:** each lasts exactly PHASE_CYCLES cycles, counted by a phase counter cleared on entry.
- **Halfword addresses:**
  - base = latched `address[SRAM_ADDR_W:2]`.
  - LOW drives `SRAM_ADDR` = {base,0}.
  - HIGH drives `SRAM_ADDR` = {base,1}.
  - Upper address bits are discarded, so addresses wrap modulo SRAM size.
- **Write phases:**
  - `SRAM_WE_N`=0 for the whole phase.
  - `SRAM_DQ` = `writeData[15:0]` in LOW, `writeData[31:16]` in HIGH.
  - Repeated SRAM writes of the same value within a phase are harmless.
- **Read phases:**
  - `SRAM_WE_N`=1 and `SRAM_DQ` is high-Z.
  - On the last edge of LOW, capture `SRAM_DQ` into `readData[15:0]`; on the last edge of HIGH, into `readData[31:16]`.
- **DONE:** lasts one cycle, then return to IDLE unconditionally. A request present in the following IDLE cycle starts a new access.
- **`ready`:** combinational.
  - ready = (IDLE && !(wr_en|rd_en)) || DONE.
  - Request inputs otherwise never feed SRAM pins combinationally; pins derive only from state and latched registers.
- **Input changes while busy:** changes to `wr_en`, `rd_en`, `address` or `writeData` outside IDLE are ignored.
- **`readData` hold:** it holds its value across writes and idle cycles; it changes only at read-phase capture edges.
- **Reset (any time, including mid-access):**
  - state → IDLE, phase counter → 0.
  - `SRAM_WE_N`=1, `SRAM_DQ` high-Z, `SRAM_ADDR`=0, `readData`=0.
  - No further SRAM write occurs.
  - After reset, `ready`=1 while no request is present.

## Timing
With the request first seen in IDLE at cycle 0 (P = PHASE_CYCLES):
- Cycle 0: `ready`=0 and the request is latched.
- Cycles 1..P: LOW phase.
- Cycles P+1..2P: HIGH phase.
- Cycle 2P+1: DONE, `ready`=1, and the full `readData` is valid.
- With P=2, `ready` is low for 5 cycles and high on cycle 5.
- The pipeline advances on the DONE-cycle edge.
- Back-to-back requests: the next access starts at cycle 2P+2 (IDLE with a request, `ready`=0 again).
- On writes, the SRAM commits both halfwords by cycle 2P.

## Test plan
- **Reset:** assert `rst`=0 mid-sim → `SRAM_WE_N`=1, `SRAM_DQ`=Z, `SRAM_ADDR`=0, `readData`=0, `ready`=1 with no request.
- **Write then read:**
  - Write 0xDEADBEEF to address 8 → SRAM[4]=0xBEEF, SRAM[5]=0xDEAD, `ready` low cycles 0–4 and high on cycle 5 (P=2).
  - Read address 8 → `readData`=0xDEADBEEF in DONE.
- **Simultaneous requests:** `wr_en`=`rd_en`=1, address 4, data 0x12345678 → SRAM[2]=0x5678, SRAM[3]=0x1234, `readData` unchanged.
- **Wrap (SRAM_ADDR_W=6):** write 0xCAFEF00D to address 256 → `SRAM_ADDR` 0 then 1, SRAM[0]=0xF00D, SRAM[1]=0xCAFE.
- **Reset mid-write:** pull `rst` low during HIGH → `SRAM_WE_N`=1 immediately, SRAM[high] unchanged, state IDLE; the next read returns the old high half.
- **Back-to-back reads** of addresses 0 and 8 with requests held → two separate 5-cycle stalls, `readData` correct in each DONE cycle, no bus contention (DQ never driven while `SRAM_WE_N`=1).
